// File: rtl/conv1_feed_pkg.sv
// Shared types and constants for the CONV1 input feed path byte FIFOs.
package conv1_feed_pkg;

  localparam int MAX_WR_BYTES = 5;
  localparam int BYTE_W       = 8;

  typedef logic [2:0] wr_len_t;

  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    READY,
    FULL
  } fifo_state_t;

endpackage

// File: rtl/conv1_byte_fifo_if.sv
// Column write/read port bundle of conv1_byte_fifo.
// Optional CONV1_BYTE_FIFO_ERR_EN adds the sticky err_ovf/err_unf flags.
interface conv1_byte_fifo_if import conv1_feed_pkg::*; #(
  parameter int DEPTH_BYTES = 32
);

  localparam int CW = $clog2(DEPTH_BYTES + 1);

  // Handshake: a write is taken on any edge where wr_en=1, wr_len is 1..5 and
  // wr_len fits in the free space (wr_ready is only the "5 bytes fit" hint);
  // a read is taken where rd_en=1 and count>=RD_BYTES, and returns its segment
  // with a one-cycle rd_valid pulse on the following cycle. Nothing stalls.
  logic                           flush;
  logic                           wr_en;
  wr_len_t                        wr_len;
  logic [MAX_WR_BYTES*BYTE_W-1:0] wr_data;
  logic                           wr_ready;
  logic                           rd_en;
  logic [MAX_WR_BYTES*BYTE_W-1:0] rd_data;
  logic                           rd_valid;
  logic                           rd_avail;
  logic [CW-1:0]                  count;
`ifdef CONV1_BYTE_FIFO_ERR_EN
  logic                           err_ovf;
  logic                           err_unf;
`endif

  modport master (
    output flush, wr_en, wr_len, wr_data, rd_en,
    input  wr_ready, rd_data, rd_valid, rd_avail, count
`ifdef CONV1_BYTE_FIFO_ERR_EN
    , input err_ovf, err_unf
`endif
  );

  modport slave (
    input  flush, wr_en, wr_len, wr_data, rd_en,
    output wr_ready, rd_data, rd_valid, rd_avail, count
`ifdef CONV1_BYTE_FIFO_ERR_EN
    , output err_ovf, err_unf
`endif
  );

endinterface

// File: rtl/conv1_byte_ring.sv
// Byte ring storage with 5 write lanes and RD_BYTES read lanes, addressed
// relative to the write/read pointers; pointer arithmetic wraps naturally.
module conv1_byte_ring import conv1_feed_pkg::*; #(
  parameter int DEPTH_BYTES = 32,
  parameter int RD_BYTES    = 5,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [AW-1:0]                  wr_ptr,
  input  wr_len_t                        wr_len,
  input  logic [MAX_WR_BYTES*BYTE_W-1:0] wr_data,
  input  logic [AW-1:0]                  rd_ptr,
  output logic [MAX_WR_BYTES*BYTE_W-1:0] rd_data
);

  logic [BYTE_W-1:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < MAX_WR_BYTES; i++) begin
        if (wr_len_t'(i) < wr_len)
          mem[wr_ptr + AW'(i)] <= wr_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Lanes above RD_BYTES stay zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < RD_BYTES; i++)
      rd_data[i*BYTE_W +: BYTE_W] = mem[rd_ptr + AW'(i)];
  end

endmodule

// File: rtl/conv1_byte_fifo.sv
// Variable-length byte FIFO feeding fixed RD_BYTES kernel-row segments to CONV1.
// Optional CONV1_BYTE_FIFO_ERR_EN adds sticky overflow/underflow flags.
module conv1_byte_fifo import conv1_feed_pkg::*; #(
  parameter int DEPTH_BYTES = 32,
  parameter int RD_BYTES    = 5
) (
  input  logic             clk,
  input  logic             rst,
  conv1_byte_fifo_if.slave bus,
  output fifo_state_t      state
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = $clog2(DEPTH_BYTES + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_BYTES);
  localparam logic [CW-1:0] RD_C    = CW'(RD_BYTES);
  localparam logic [CW-1:0] MAXW_C  = CW'(MAX_WR_BYTES);

  logic [AW-1:0]                  wr_ptr, rd_ptr;
  logic [CW-1:0]                  count_q, count_d, free, wr_len_c;
  logic                           len_ok, wr_acc, rd_acc, wr_drop, rd_rej;
  logic [MAX_WR_BYTES*BYTE_W-1:0] ring_rd, rd_data_q;
  logic                           rd_valid_q;
  fifo_state_t                    state_q, state_d;

  assign free     = DEPTH_C - count_q;
  assign wr_len_c = CW'(bus.wr_len);
  assign len_ok   = (bus.wr_len != '0) && (wr_len_c <= MAXW_C);
  // Space is judged on the pre-read count, so a same-cycle read never helps.
  assign wr_acc   = !bus.flush && bus.wr_en && len_ok && (wr_len_c <= free);
  assign wr_drop  = !bus.flush && bus.wr_en && len_ok && (wr_len_c > free);
  assign rd_acc   = !bus.flush && bus.rd_en && (count_q >= RD_C);
  assign rd_rej   = !bus.flush && bus.rd_en && (count_q < RD_C);

  conv1_byte_ring #(
    .DEPTH_BYTES(DEPTH_BYTES),
    .RD_BYTES   (RD_BYTES)
  ) u_ring (
    .clk    (clk),
    .we     (wr_acc),
    .wr_ptr (wr_ptr),
    .wr_len (bus.wr_len),
    .wr_data(bus.wr_data),
    .rd_ptr (rd_ptr),
    .rd_data(ring_rd)
  );

  always_comb begin
    count_d = count_q;
    if (bus.flush) begin
      count_d = '0;
    end else begin
      if (wr_acc) count_d = count_d + wr_len_c;
      if (rd_acc) count_d = count_d - RD_C;
    end
  end

  always_comb begin
    state_d = state_q;
    if (count_d == '0)          state_d = EMPTY;
    else if (count_d < RD_C)    state_d = FILLING;
    else if (count_d == DEPTH_C) state_d = FULL;
    else                        state_d = READY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_valid_q <= rd_acc;
      if (bus.flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(bus.wr_len);
        if (rd_acc) begin
          rd_ptr    <= rd_ptr + AW'(RD_BYTES);
          rd_data_q <= ring_rd;
        end
      end
    end
  end

`ifdef CONV1_BYTE_FIFO_ERR_EN
  logic err_ovf_q, err_unf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else if (bus.flush) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_q | wr_drop;
      err_unf_q <= err_unf_q | rd_rej;
    end
  end

  assign bus.err_ovf = err_ovf_q;
  assign bus.err_unf = err_unf_q;
`else
  logic unused_drop;
  assign unused_drop = wr_drop ^ rd_rej;
`endif

  assign bus.count    = count_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_avail = (state_q == READY) || (state_q == FULL);
  assign bus.wr_ready = (free >= MAXW_C);
  assign state        = state_q;

endmodule

// File: tb/tb_conv1_byte_fifo.sv
// Self-checking bench for conv1_byte_fifo: byte scoreboard plus per-scenario checks.
module tb_conv1_byte_fifo;
  import conv1_feed_pkg::*;

  localparam int DEPTH = 32;
  localparam int RD    = 5;

  logic        clk = 1'b0;
  logic        rst;
  fifo_state_t state;

  conv1_byte_fifo_if #(.DEPTH_BYTES(DEPTH)) bus ();

  conv1_byte_fifo #(
    .DEPTH_BYTES(DEPTH),
    .RD_BYTES   (RD)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .state(state)
  );

  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [7:0]  exp_q[$];
  logic [39:0] mon_w;
  logic [39:0] last_seg = '0;
  int n_checks = 0;
  int n_pass   = 0;
  int m_count  = 0;
  int seg_exp  = 0;
  int seg_seen = 0;
  logic m_ovf = 1'b0;
  logic m_unf = 1'b0;

  always @(negedge clk) begin
    if (rst === 1'b0 && bus.rd_valid === 1'b1) begin
      seg_seen++;
      n_checks++;
      if (exp_q.size() < RD) begin
        $display("FAIL sb_underrun got segment %h with only %0d bytes expected", bus.rd_data, exp_q.size());
      end else begin
        mon_w = '0;
        for (int i = 0; i < RD; i++) mon_w[i*8 +: 8] = exp_q.pop_front();
        last_seg = mon_w;
        if (bus.rd_data !== mon_w)
          $display("FAIL sb_segment got %h exp %h", bus.rd_data, mon_w);
        else
          n_pass++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_cycle(input logic we, input wr_len_t len, input logic [39:0] data,
                          input logic re, input logic fl);
    logic lok, wacc, racc;
    @(negedge clk);
    bus.wr_en   = we;
    bus.wr_len  = len;
    bus.wr_data = data;
    bus.rd_en   = re;
    bus.flush   = fl;
    lok  = (len >= 3'd1) && (len <= 3'd5);
    wacc = we && lok && (int'(len) <= DEPTH - m_count) && !fl;
    racc = re && (m_count >= RD) && !fl;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0; bus.wr_len = '0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.flush = 1'b0;
    if (fl) begin
      exp_q.delete();
      m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      if (we && lok && !wacc) m_ovf = 1'b1;
      if (re && !racc) m_unf = 1'b1;
      if (racc) begin m_count -= RD; seg_exp++; end
      if (wacc) begin
        for (int i = 0; i < int'(len); i++) exp_q.push_back(data[i*8 +: 8]);
        m_count += int'(len);
      end
    end
  endtask

  function automatic logic [39:0] rnd40();
    return {8'($urandom_range(255)), 32'($urandom)};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_len = '0; bus.wr_data = '0; bus.rd_en = 1'b0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.count !== 6'd0) $display("FAIL reset_count got %0d exp 0", bus.count); else n_pass++;
    n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); else n_pass++;
    n_checks++; if (bus.rd_avail !== 1'b0) $display("FAIL reset_rd_avail got %b exp 0", bus.rd_avail); else n_pass++;
    n_checks++; if (bus.wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b exp 1", bus.wr_ready); else n_pass++;
    n_checks++; if (bus.rd_data !== 40'h0) $display("FAIL reset_rd_data got %h exp 0", bus.rd_data); else n_pass++;
    n_checks++; if (state !== EMPTY) $display("FAIL reset_state got %0d exp EMPTY", state); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_even();
    do_cycle(1'b1, 3'd4, 40'h0044332211, 1'b0, 1'b0);
    n_checks++; if (bus.count !== 6'd4) $display("FAIL even_count4 got %0d exp 4", bus.count); else n_pass++;
    n_checks++; if (state !== FILLING || bus.rd_avail !== 1'b0) $display("FAIL even_filling got state %0d avail %b exp FILLING/0", state, bus.rd_avail); else n_pass++;
    do_cycle(1'b1, 3'd1, 40'h0000000055, 1'b0, 1'b0);
    n_checks++; if (bus.count !== 6'd5) $display("FAIL even_count5 got %0d exp 5", bus.count); else n_pass++;
    n_checks++; if (state !== READY || bus.rd_avail !== 1'b1) $display("FAIL even_ready got state %0d avail %b exp READY/1", state, bus.rd_avail); else n_pass++;
    do_cycle(1'b0, 3'd0, 40'h0, 1'b1, 1'b0);
    n_checks++; if (bus.rd_valid !== 1'b1) $display("FAIL even_rd_valid got %b exp 1", bus.rd_valid); else n_pass++;
    n_checks++; if (bus.rd_data !== 40'h5544332211) $display("FAIL even_rd_data got %h exp 5544332211", bus.rd_data); else n_pass++;
    n_checks++; if (bus.count !== 6'd0 || state !== EMPTY) $display("FAIL even_count0 got %0d state %0d exp 0/EMPTY", bus.count, state); else n_pass++;
  endtask

  task automatic test_odd();
    do_cycle(1'b1, 3'd2, 40'h000000BBAA, 1'b0, 1'b0);
    do_cycle(1'b1, 3'd3, 40'h0000EEDDCC, 1'b0, 1'b0);
    do_cycle(1'b0, 3'd0, 40'h0, 1'b1, 1'b0);
    n_checks++; if (bus.rd_data !== 40'hEEDDCCBBAA || bus.rd_valid !== 1'b1) $display("FAIL odd_rd_data got %h valid %b exp EEDDCCBBAA/1", bus.rd_data, bus.rd_valid); else n_pass++;
    do_cycle(1'b0, 3'd0, 40'h0, 1'b0, 1'b0);
    n_checks++; if (bus.rd_valid !== 1'b0) $display("FAIL odd_pulse got %b exp 0", bus.rd_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 6; k++) do_cycle(1'b1, 3'd5, rnd40(), 1'b0, 1'b0);
    n_checks++; if (bus.count !== 6'd30) $display("FAIL ovf_count30 got %0d exp 30", bus.count); else n_pass++;
    n_checks++; if (bus.wr_ready !== 1'b0) $display("FAIL ovf_wr_ready got %b exp 0", bus.wr_ready); else n_pass++;
    do_cycle(1'b1, 3'd5, rnd40(), 1'b0, 1'b0);
    n_checks++; if (bus.count !== 6'd30) $display("FAIL ovf_drop got %0d exp 30", bus.count); else n_pass++;
`ifdef CONV1_BYTE_FIFO_ERR_EN
    n_checks++; if (bus.err_ovf !== m_ovf || m_ovf !== 1'b1) $display("FAIL ovf_err got %b exp 1", bus.err_ovf); else n_pass++;
`endif
    do_cycle(1'b1, 3'd0, rnd40(), 1'b0, 1'b0);
    do_cycle(1'b1, 3'd6, rnd40(), 1'b0, 1'b0);
    do_cycle(1'b1, 3'd7, rnd40(), 1'b0, 1'b0);
    n_checks++; if (bus.count !== 6'd30) $display("FAIL len_noop got %0d exp 30", bus.count); else n_pass++;
    do_cycle(1'b1, 3'd2, rnd40(), 1'b0, 1'b0);
    n_checks++; if (bus.count !== 6'd32 || state !== FULL) $display("FAIL full_state got %0d state %0d exp 32/FULL", bus.count, state); else n_pass++;
    do_cycle(1'b1, 3'd1, rnd40(), 1'b0, 1'b0);
    n_checks++; if (bus.count !== 6'd32 || bus.wr_ready !== 1'b0) $display("FAIL full_drop got %0d ready %b exp 32/0", bus.count, bus.wr_ready); else n_pass++;
    for (int k = 0; k < 6; k++) begin
      do_cycle(1'b0, 3'd0, 40'h0, 1'b1, 1'b0);
      n_checks++; if (bus.rd_valid !== 1'b1) $display("FAIL drain_valid got %b exp 1 at read %0d", bus.rd_valid, k); else n_pass++;
    end
    n_checks++; if (bus.count !== 6'd2 || state !== FILLING) $display("FAIL drain_count got %0d state %0d exp 2/FILLING", bus.count, state); else n_pass++;
    do_cycle(1'b0, 3'd0, 40'h0, 1'b1, 1'b0);
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== last_seg) $display("FAIL unf_hold got valid %b data %h exp 0/%h", bus.rd_valid, bus.rd_data, last_seg); else n_pass++;
    n_checks++; if (bus.count !== 6'd2) $display("FAIL unf_count got %0d exp 2", bus.count); else n_pass++;
`ifdef CONV1_BYTE_FIFO_ERR_EN
    n_checks++; if (bus.err_unf !== m_unf || m_unf !== 1'b1) $display("FAIL unf_err got %b exp 1", bus.err_unf); else n_pass++;
`endif
    do_cycle(1'b0, 3'd0, 40'h0, 1'b0, 1'b1);
    n_checks++; if (bus.count !== 6'd0) $display("FAIL ovf_flush got %0d exp 0", bus.count); else n_pass++;
`ifdef CONV1_BYTE_FIFO_ERR_EN
    n_checks++; if (bus.err_ovf !== 1'b0 || bus.err_unf !== 1'b0) $display("FAIL err_clear got %b%b exp 00", bus.err_ovf, bus.err_unf); else n_pass++;
`endif
  endtask

  task automatic test_wrap();
    do_cycle(1'b1, 3'd5, rnd40(), 1'b0, 1'b0);
    do_cycle(1'b1, 3'd3, rnd40(), 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      do_cycle(1'b1, 3'd5, rnd40(), 1'b1, 1'b0);
      n_checks++; if (bus.rd_valid !== 1'b1 || bus.count !== 6'd8) $display("FAIL wrap_step got valid %b count %0d exp 1/8 at %0d", bus.rd_valid, bus.count, k); else n_pass++;
    end
    do_cycle(1'b0, 3'd0, 40'h0, 1'b1, 1'b0);
    n_checks++; if (bus.count !== 6'd3) $display("FAIL wrap_tail got %0d exp 3", bus.count); else n_pass++;
    do_cycle(1'b0, 3'd0, 40'h0, 1'b0, 1'b1);
  endtask

  task automatic test_simultaneous();
    do_cycle(1'b1, 3'd5, 40'h0504030201, 1'b0, 1'b0);
    n_checks++; if (bus.count !== 6'd5) $display("FAIL simul_pre got %0d exp 5", bus.count); else n_pass++;
    do_cycle(1'b1, 3'd3, 40'hFFFF0A0908, 1'b1, 1'b0);
    n_checks++; if (bus.count !== 6'd3) $display("FAIL simul_count got %0d exp 3", bus.count); else n_pass++;
    n_checks++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 40'h0504030201) $display("FAIL simul_data got %b/%h exp 1/0504030201", bus.rd_valid, bus.rd_data); else n_pass++;
    do_cycle(1'b1, 3'd2, 40'h0000000C0B, 1'b0, 1'b0);
    do_cycle(1'b0, 3'd0, 40'h0, 1'b1, 1'b0);
    n_checks++; if (bus.rd_data !== 40'h0C0B0A0908) $display("FAIL simul_next got %h exp 0C0B0A0908", bus.rd_data); else n_pass++;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) do_cycle(1'b1, 3'd4, rnd40(), 1'b0, 1'b0);
    do_cycle(1'b1, 3'd5, rnd40(), 1'b0, 1'b0);
    do_cycle(1'b0, 3'd0, 40'h0, 1'b1, 1'b0);
    n_checks++; if (bus.count !== 6'd12 || bus.rd_valid !== 1'b1) $display("FAIL flush_pre got %0d/%b exp 12/1", bus.count, bus.rd_valid); else n_pass++;
    do_cycle(1'b1, 3'd5, rnd40(), 1'b1, 1'b1);
    n_checks++; if (bus.count !== 6'd0 || bus.rd_valid !== 1'b0) $display("FAIL flush_clear got %0d/%b exp 0/0", bus.count, bus.rd_valid); else n_pass++;
    n_checks++; if (state !== EMPTY || bus.rd_avail !== 1'b0 || bus.wr_ready !== 1'b1) $display("FAIL flush_flags got state %0d avail %b ready %b exp EMPTY/0/1", state, bus.rd_avail, bus.wr_ready); else n_pass++;
    do_cycle(1'b1, 3'd2, 40'h0000002211, 1'b0, 1'b0);
    n_checks++; if (bus.count !== 6'd2) $display("FAIL flush_wr_ignored got %0d exp 2", bus.count); else n_pass++;
    do_cycle(1'b0, 3'd0, 40'h0, 1'b0, 1'b1);
  endtask

  task automatic test_async_reset();
    do_cycle(1'b1, 3'd5, 40'hA5A4A3A2A1, 1'b0, 1'b0);
    do_cycle(1'b1, 3'd5, rnd40(), 1'b0, 1'b0);
    do_cycle(1'b0, 3'd0, 40'h0, 1'b1, 1'b0);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_len = 3'd5; bus.wr_data = rnd40(); bus.rd_en = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (bus.count !== 6'd0 || state !== EMPTY) $display("FAIL arst_count got %0d state %0d exp 0/EMPTY", bus.count, state); else n_pass++;
    n_checks++; if (bus.rd_valid !== 1'b0 || bus.rd_data !== 40'h0) $display("FAIL arst_rd got %b/%h exp 0/0", bus.rd_valid, bus.rd_data); else n_pass++;
    n_checks++; if (bus.rd_avail !== 1'b0 || bus.wr_ready !== 1'b1) $display("FAIL arst_flags got avail %b ready %b exp 0/1", bus.rd_avail, bus.wr_ready); else n_pass++;
    bus.wr_en = 1'b0; bus.wr_len = '0; bus.wr_data = '0; bus.rd_en = 1'b0;
    exp_q.delete();
    m_count = 0; m_ovf = 1'b0; m_unf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_cycle(1'b1, 3'd5, 40'h0102030405, 1'b0, 1'b0);
    do_cycle(1'b0, 3'd0, 40'h0, 1'b1, 1'b0);
    n_checks++; if (bus.rd_data !== 40'h0102030405) $display("FAIL arst_recover got %h exp 0102030405", bus.rd_data); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_overflow();
    test_wrap();
    test_simultaneous();
    test_flush();
    test_async_reset();
    repeat (2) @(posedge clk);
    n_checks++; if (seg_seen !== seg_exp) $display("FAIL seg_total got %0d exp %0d", seg_seen, seg_exp); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/conv1_byte_fifo.md
# conv1_byte_fifo

Variable-length byte FIFO forming the consumer end of the CONV1 input feed path. One instance sits on each of the four column write ports (wr_en/wr_len/wr_data). It absorbs 1–5-byte write bursts and hands fixed 5-byte kernel-row segments to the CONV1 processing element on request. It repacks the uneven even/odd-channel byte split back into aligned 40-bit words.

## Interface
- DEPTH_BYTES, 32, ring capacity in bytes; power of two, at least 8
- RD_BYTES, 5, bytes returned per read; fixed kernel width, at most 5
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- flush  input  1  synchronous clear of contents; highest priority
- wr_en  input  1  write strobe
- wr_len  input  3  byte count of this write; 1..5 valid
- wr_data  input  40  write bytes; wr_data[7:0] is the oldest byte
- wr_ready  output  1  free space ≥ 5 bytes
- rd_en  input  1  request one RD_BYTES segment
- rd_data  output  40  segment; [7:0] oldest byte; unused upper bytes are zero
- rd_valid  output  1  rd_data holds a newly popped segment (1-cycle pulse)
- rd_avail  output  1  count ≥ RD_BYTES
- count  output  $clog2(DEPTH_BYTES+1)  bytes stored

## Operation
- Storage: byte ring of DEPTH_BYTES, with wr_ptr/rd_ptr modulo DEPTH_BYTES (natural wrap) and a count register.
- Write acceptance requires all of: wr_en=1, wr_len in 1..5, and wr_len ≤ DEPTH_BYTES−count.
  - Accepted write: bytes 0..wr_len−1 are stored at wr_ptr+i, wr_ptr+=wr_len, count+=wr_len.
  - wr_len of 0, 6 or 7 is a no-op.
  - Insufficient space drops the whole write (no partial write).
- Read acceptance requires rd_en=1 and count ≥ RD_BYTES (evaluated on the count register before this cycle's write).
  - Accepted read: next cycle rd_data = bytes rd_ptr..rd_ptr+RD_BYTES−1 and rd_valid=1. rd_ptr+=RD_BYTES, count−=RD_BYTES.
  - Rejected read: rd_valid=0 next cycle, rd_data holds its previous value.
- Simultaneous accepted read and write: count += wr_len − RD_BYTES in one cycle. Space for the write is computed from the pre-read count (conservative). No write-to-read bypass.
- flush=1: pointers and count go to 0 next cycle and rd_valid goes to 0. A write or read in the same cycle is discarded.
- Read-side state machine:
  - EMPTY (count=0) → FILLING (0<count<RD_BYTES) → READY (count≥RD_BYTES) → FULL (count=DEPTH_BYTES).
  - Transitions follow the updated count each cycle.
  - rd_avail = state ∈ {READY, FULL}.
  - wr_ready = free ≥ 5; it is 0 in FULL, and in any state with free < 5.

## Timing
- Reset values:
  - count=0, pointers=0, state=EMPTY.
  - rd_data=0, rd_valid=0, rd_avail=0, wr_ready=1.
- Write-to-visible latency: 1 cycle. count and rd_avail update on the edge that captures the write.
- Read latency: 1 cycle from the rd_en edge to rd_valid/rd_data; fully pipelined (back-to-back reads allowed).
- wr_ready, rd_avail and count are registered-derived. They reflect the state after the last edge.
- Reset mid-burst: all state returns to reset values immediately. Bytes held in the feed pipeline are lost; the upstream re-sequences.

## Configuration
- CONV1_BYTE_FIFO_ERR_EN
  - Defined: adds outputs err_ovf and err_unf, each 1 bit. They are sticky, set on a dropped write (wr_en with valid wr_len but insufficient space) or a rejected read (rd_en with count < RD_BYTES), and cleared only by rst or flush.
  - Undefined: the ports and their logic are absent, and drops are silent.

## Structure
- Package conv1_feed_pkg: MAX_WR_BYTES=5, BYTE_W=8, the wr_len_t typedef (3-bit), and the fifo_state_t enum (EMPTY, FILLING, READY, FULL).
- Sub-module conv1_byte_ring: a DEPTH_BYTES×8 register array with 5 write lanes and 5 read lanes and pointer-rotated addressing. The top level holds pointers, count, FSM and output registers.

## Test plan
- Even-channel pattern:
  - Stimulus: write len4 data 0x0044332211, then len1 data 0x55, then rd_en.
  - Required: rd_valid with rd_data=0x5544332211, count 5→0.
- Odd-channel pattern:
  - Stimulus: write len2 0xBBAA, then len3 0xEEDDCC, then rd_en.
  - Required: rd_data=0xEEDDCCBBAA.
- Overflow:
  - Stimulus: fill to 30 bytes, then write len5.
  - Required: write dropped, count stays 30, wr_ready=0, err_ovf=1 (with _EN).
- Wrap-around:
  - Stimulus: 7 cycles of write len5 + read interleaved across the 32-byte boundary.
  - Required: every segment returns in order, with no byte loss or duplication.
- Simultaneous:
  - Stimulus: count=5; in one cycle write len3 and rd_en.
  - Required: count=3 next cycle, and rd_data holds the first 5 bytes.
- Flush and reset:
  - Stimulus: count=12; assert flush together with wr_en and rd_en.
  - Required: count=0, rd_valid=0, and the write is ignored.
  - Stimulus: repeat with rst asserted mid-cycle.
  - Required: all outputs at reset values asynchronously.
